// File: rtl/led_breathe_pwm.sv
// LED "breathing" driver: a PWM output whose duty ramps up, holds at full
// brightness, then ramps down. The ramp repeats while EN is held and fades out
// when EN drops. The applied duty only changes at a PWM period boundary, so
// no period is ever cut short.
module led_breathe_pwm #(
    parameter int PWM_BITS   = 8,
    parameter int STEP_DIV   = 195312,
    parameter int HOLD_STEPS = 32
) (
    input  logic                FPGA_CLK,
    input  logic                RST,
    input  logic                EN,
    output logic                F_LED,
    output logic [PWM_BITS-1:0] DUTY,
    output logic [1:0]          PHASE
);

    localparam logic [PWM_BITS-1:0] MAX = '1;
    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);

    typedef enum logic [1:0] {
        S_OFF  = 2'b00,
        S_UP   = 2'b01,
        S_HOLD = 2'b10,
        S_DOWN = 2'b11
    } state_t;

    state_t              r_state;
    logic [PWM_BITS-1:0] r_target;
    logic [PWM_BITS-1:0] r_duty;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [SW-1:0]       r_step_cnt;
    logic [HW-1:0]       r_hold_cnt;
    logic                r_led;

    state_t              w_state_nxt;
    logic [PWM_BITS-1:0] w_target_nxt;
    logic [HW-1:0]       w_hold_nxt;
    logic                w_step_tick;

    // The prescaler only runs outside OFF, so a tick in OFF can never occur.
    assign w_step_tick = (r_state != S_OFF) && (r_step_cnt == STEP_LAST);

    // State, ramp target and hold counter registers.
    always_ff @(posedge FPGA_CLK) begin
        if (RST) begin
            r_state    <= S_OFF;
            r_target   <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_target   <= w_target_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Next-state and ramp rules. An EN drop in UP/HOLD wins over a
    // coincident step tick. DOWN always finishes its ramp regardless of EN.
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_hold_nxt   = r_hold_cnt;
        case (r_state)
            S_OFF: begin
                w_target_nxt = '0;
                w_hold_nxt   = '0;
                if (EN) begin
                    w_state_nxt = S_UP;
                end
            end
            S_UP: begin
                if (!EN) begin
                    w_state_nxt = S_DOWN;
                end else if (w_step_tick) begin
                    if (r_target == MAX) begin
                        w_state_nxt = S_HOLD;
                        w_hold_nxt  = '0;
                    end else begin
                        w_target_nxt = r_target + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (!EN) begin
                    w_state_nxt = S_DOWN;
                end else if (w_step_tick) begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_state_nxt = S_DOWN;
                    end else begin
                        w_hold_nxt = r_hold_cnt + 1'b1;
                    end
                end
            end
            S_DOWN: begin
                if (w_step_tick) begin
                    if (r_target == '0) begin
                        w_state_nxt = EN ? S_UP : S_OFF;
                    end else begin
                        w_target_nxt = r_target - 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_OFF;
            end
        endcase
    end

    // Step prescaler: parked at zero in OFF, otherwise wraps every STEP_DIV clocks.
    always_ff @(posedge FPGA_CLK) begin
        if (RST || r_state == S_OFF || w_step_tick) begin
            r_step_cnt <= '0;
        end else begin
            r_step_cnt <= r_step_cnt + 1'b1;
        end
    end

    // Free-running PWM counter, period-aligned duty load and registered LED drive.
    always_ff @(posedge FPGA_CLK) begin
        if (RST) begin
            r_pwm_cnt <= '0;
            r_duty    <= '0;
            r_led     <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_led     <= (r_pwm_cnt < r_duty);
            if (r_pwm_cnt == MAX) begin
                r_duty <= r_target;
            end
        end
    end

    assign F_LED = r_led;
    assign DUTY  = r_duty;
    assign PHASE = r_state;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Bench for led_breathe_pwm: directed scenarios followed by randomized EN/RST,
// with every output compared each cycle against a behavioural model. Each
// completed PWM period is also checked so that its count of lit cycles equals
// the duty applied during that period.
`timescale 1ns/1ps
module tb_led_breathe_pwm;

    localparam int PWM_BITS   = 3;
    localparam int STEP_DIV   = 2;
    localparam int HOLD_STEPS = 1;
    localparam int MAXV       = (1 << PWM_BITS) - 1;

    localparam int P_OFF  = 0;
    localparam int P_UP   = 1;
    localparam int P_HOLD = 2;
    localparam int P_DOWN = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en  = 1'b0;
    logic                f_led;
    logic [PWM_BITS-1:0] duty;
    logic [1:0]          phase;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_phase, m_target, m_duty, m_pwm, m_step, m_holds, m_led;
    // Per-period lit-cycle accounting.
    int win_ones, win_duty;
    bit win_valid;

    led_breathe_pwm #(
        .PWM_BITS  (PWM_BITS),
        .STEP_DIV  (STEP_DIV),
        .HOLD_STEPS(HOLD_STEPS)
    ) dut (
        .FPGA_CLK(clk),
        .RST     (rst),
        .EN      (en),
        .F_LED   (f_led),
        .DUTY    (duty),
        .PHASE   (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural rules applied once per rising edge with the inputs seen there.
    task automatic model_edge(input bit r, input bit e);
        bit tick;
        if (r) begin
            m_phase = P_OFF; m_target = 0; m_duty = 0; m_pwm = 0;
            m_step = 0; m_holds = 0; m_led = 0;
        end else begin
            m_led = (m_pwm < m_duty) ? 1 : 0;
            if (m_pwm == MAXV) m_duty = m_target;
            m_pwm = (m_pwm + 1) % (MAXV + 1);
            tick = (m_phase != P_OFF) && (m_step == STEP_DIV - 1);
            m_step = (m_phase == P_OFF) ? 0 : (m_step + 1) % STEP_DIV;
            case (m_phase)
                P_OFF: if (e) m_phase = P_UP;
                P_UP: begin
                    if (!e) m_phase = P_DOWN;
                    else if (tick) begin
                        if (m_target == MAXV) begin
                            m_phase = P_HOLD;
                            m_holds = 0;
                        end else m_target = m_target + 1;
                    end
                end
                P_HOLD: begin
                    if (!e) m_phase = P_DOWN;
                    else if (tick) begin
                        m_holds = m_holds + 1;
                        if (m_holds == HOLD_STEPS) m_phase = P_DOWN;
                    end
                end
                default: begin
                    if (tick) begin
                        if (m_target == 0) m_phase = e ? P_UP : P_OFF;
                        else m_target = m_target - 1;
                    end
                end
            endcase
        end
    endtask

    // One clock: advance model, then compare outputs 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        model_edge(rst, en);
        #1;
        chk("F_LED", 32'(f_led), 32'(m_led));
        chk("DUTY", 32'(duty), 32'(m_duty));
        chk("PHASE", 32'(phase), 32'(m_phase));
        if (rst) begin
            win_valid = 1'b0;
            win_ones  = 0;
        end else begin
            win_ones += int'(f_led);
            if (m_pwm == 0) begin
                if (win_valid) chk("PWM_ONES", 32'(win_ones), 32'(win_duty));
                win_valid = 1'b1;
                win_ones  = 0;
                win_duty  = m_duty;
            end
        end
    endtask

    initial begin
        bit ok;
        bit seen_hold;
        bit seen_off;
        win_valid = 1'b0;
        win_ones  = 0;
        win_duty  = 0;

        // Reset, then idle with EN low.
        rst = 1'b1; en = 1'b0;
        repeat (3) step();
        chk("RST_LED", 32'(f_led), 32'd0);
        chk("RST_DUTY", 32'(duty), 32'd0);
        chk("RST_PHASE", 32'(phase), 32'd0);
        rst = 1'b0;
        repeat (100) step();
        chk("IDLE_PHASE", 32'(phase), 32'd0);

        // Continuous EN: full breathing cycles, never back to OFF.
        en = 1'b1; seen_hold = 1'b0; seen_off = 1'b0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (phase == 2'b10) seen_hold = 1'b1;
            if (m_phase == P_OFF) seen_off = 1'b1;
        end
        chk("HOLD_SEEN", 32'(seen_hold), 32'd1);
        chk("NO_OFF", 32'(seen_off), 32'd0);

        // Drop EN at target 5 in UP: immediate fade out to OFF.
        ok = (m_phase == P_UP && m_target == 5);
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            ok = (m_phase == P_UP && m_target == 5);
        end
        chk("WAIT_UP5", 32'(ok), 32'd1);
        en = 1'b0;
        step();
        chk("DROP_DOWN", 32'(phase), 32'd3);
        chk("DROP_DUTY_KEEP_TGT", 32'(m_target), 32'd5);
        ok = (m_phase == P_OFF);
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            ok = (m_phase == P_OFF);
        end
        chk("WAIT_OFF", 32'(ok), 32'd1);
        repeat (16) step();
        chk("OFF_LED", 32'(f_led), 32'd0);

        // EN pulse in DOWN at target 4 must not reverse the ramp.
        en = 1'b1;
        ok = (m_phase == P_HOLD);
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            ok = (m_phase == P_HOLD);
        end
        chk("WAIT_HOLD", 32'(ok), 32'd1);
        en = 1'b0;
        ok = (m_phase == P_DOWN && m_target == 4);
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            ok = (m_phase == P_DOWN && m_target == 4);
        end
        chk("WAIT_DOWN4", 32'(ok), 32'd1);
        en = 1'b1;
        step();
        chk("PULSE_DOWN", 32'(phase), 32'd3);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("KEEP_DOWN", 32'(phase), 32'd3);
        end
        en = 1'b1;
        ok = (m_phase != P_DOWN);
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            ok = (m_phase != P_DOWN);
        end
        chk("WAIT_DOWN_END", 32'(ok), 32'd1);
        chk("REUP_PHASE", 32'(phase), 32'd1);

        // Reset in HOLD while the LED is lit.
        ok = (m_phase == P_HOLD && m_led == 1);
        for (int i = 0; i < 400 && !ok; i++) begin
            step();
            ok = (m_phase == P_HOLD && m_led == 1);
        end
        chk("WAIT_HOLD_LIT", 32'(ok), 32'd1);
        rst = 1'b1;
        step();
        chk("MIDRST_LED", 32'(f_led), 32'd0);
        chk("MIDRST_DUTY", 32'(duty), 32'd0);
        chk("MIDRST_PHASE", 32'(phase), 32'd0);
        rst = 1'b0; en = 1'b1;
        step();
        chk("POSTRST_UP", 32'(phase), 32'd1);

        // Randomized EN toggling with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19, 0) == 0) en = ~en;
            rst = ($urandom_range(299, 0) == 0);
            step();
        end
        rst = 1'b0;
        repeat (8) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_breathe_pwm.md
LED_BREATHE_PWM -- requirements
Module: led_breathe_pwm

Interface
REQ-001 Parameter PWM_BITS, default 8, SHALL set duty/PWM counter width; MAX = 2^PWM_BITS-1.
REQ-002 Parameter STEP_DIV, default 195312, SHALL set clocks per duty step (~1 s full ramp at 50 MHz, 8 bits); legal range >=1.
REQ-003 Parameter HOLD_STEPS, default 32, SHALL set number of step ticks spent at full brightness; legal range >=1.
REQ-004 FPGA_CLK  in  1  single clock, all logic on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 EN  in  1  level request to breathe, e.g. from the blink toggle; synchronous to FPGA_CLK.
REQ-007 F_LED  out  1  registered PWM LED drive, 1 = lit.
REQ-008 DUTY  out  PWM_BITS  current applied duty value.
REQ-009 PHASE  out  2  FSM state: 00 OFF, 01 UP, 10 HOLD, 11 DOWN.

Function
REQ-010 pwm_cnt SHALL be a free-running PWM_BITS counter, incrementing every cycle and wrapping MAX->0.
REQ-011 F_LED SHALL be registered as (pwm_cnt < duty_q); duty_q 0 -> constantly 0; duty_q MAX -> high MAX of every 2^PWM_BITS cycles.
REQ-012 duty_q SHALL load the target duty only in the cycle pwm_cnt == MAX, so no PWM period is truncated or glitched.
REQ-013 DUTY SHALL output duty_q.
REQ-014 Step prescaler step_cnt SHALL count 0..STEP_DIV-1 and wrap; step_tick SHALL be high exactly one cycle when step_cnt == STEP_DIV-1.
REQ-015 In OFF, target duty SHALL be 0, step_cnt held at 0; EN=1 -> UP next cycle.
REQ-016 In UP, each step_tick SHALL increment target by 1; tick with target == MAX -> HOLD, target stays MAX (no wrap).
REQ-017 In HOLD, target SHALL stay MAX; after HOLD_STEPS step_ticks -> DOWN; hold counter cleared on HOLD entry.
REQ-018 In DOWN, each step_tick SHALL decrement target by 1; tick with target == 0 -> UP if EN=1, else OFF; target never underflows.
REQ-019 EN=0 while in UP or HOLD SHALL force DOWN next cycle, target unchanged (fade out from current level).
REQ-020 EN=1 while in DOWN SHALL NOT reverse direction; the ramp completes to 0, then REQ-018 applies.
REQ-021 step_tick coincident with EN change: EN transition rule (REQ-019) SHALL take priority; step not applied in that cycle.
REQ-022 Continuous EN=1 SHALL produce endless UP->HOLD->DOWN->UP cycles without passing through OFF.

Reset
REQ-023 RST=1 at a clock edge SHALL set PHASE=00, target=0, duty_q=0, pwm_cnt=0, step_cnt=0, hold counter=0, F_LED=0 from the next cycle.
REQ-024 RST SHALL override all other inputs, including mid-ramp and mid-PWM-period; first cycle after release behaves as OFF.

Verification (PWM_BITS=3, STEP_DIV=2, HOLD_STEPS=1 unless stated)
REQ-025 RST 3 cycles, EN=0 for 100 cycles -> F_LED=0, DUTY=0, PHASE=00 throughout.
REQ-026 EN=1 held -> PHASE 01, target 0..7 one step per 2 clocks, PHASE 10 for 2 clocks, PHASE 11 down to 0, back to 01; DUTY changes only after pwm_cnt==7.
REQ-027 DUTY=3 applied -> F_LED high exactly 3 of each 8 cycles; DUTY=7 -> 7 of 8; DUTY=0 -> 0 of 8.
REQ-028 EN=1 until target=5 in UP, then EN=0 -> PHASE=11 next cycle, target 5,4,..,0, then PHASE=00, F_LED stays 0.
REQ-029 In DOWN at target=4, pulse EN=1 -> ramp continues to 0, then PHASE=01.
REQ-030 RST asserted mid-HOLD with F_LED=1 -> next cycle all outputs 0, PHASE=00; release with EN=1 -> PHASE=01 one cycle later.
